// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package bus_pkg;
  localparam int          ADDR_W_DEF    = 12;
  localparam int          DATA_W_DEF    = 8;
  localparam logic [3:0]  TB_PAGE_DEF   = 4'h4;
  localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on contention the master that did not win last time gets the bus.
module rr_arb2 (
  input  logic [1:0] i_elig,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_winner
);
  always_comb begin
    o_valid  = |i_elig;
    o_winner = (&i_elig) ? ~i_last : i_elig[1];
  end
endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates two masters onto the peripheral bus and sequences text-buffer strobes.
// Every output is a register; the comb block computes next-cycle values.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter int         DATA_W      = DATA_W_DEF,
  parameter logic [3:0] TB_PAGE     = TB_PAGE_DEF,
  parameter int         RD_LAT      = 1,
  parameter bit         VBLANK_ONLY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_do,
  input  logic [DATA_W-1:0] bus_di,
  output logic              tb_we,
  output logic              tb_oe,
  output logic              busy,
  output logic              grant_id
);
  localparam logic [1:0] WAIT_N = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  logic [1:0]                    w_req, w_rw, w_map, w_elig;
  logic [1:0][ADDR_W-1:0]        w_addr;
  logic [1:0][DATA_W-1:0]        w_wdata;
  logic                          w_valid, w_win;

  state_t                        r_state, w_state_nxt;
  logic                          r_rw, r_map, r_gid, r_last, r_we, r_oe, r_busy;
  logic [1:0]                    r_cnt, r_ack;
  logic [ADDR_W-1:0]             r_addr;
  logic [DATA_W-1:0]             r_do;
  logic [1:0][DATA_W-1:0]        r_rdata;

  logic                          w_rw_nxt, w_map_nxt, w_gid_nxt, w_last_nxt, w_we_nxt, w_oe_nxt;
  logic [1:0]                    w_cnt_nxt, w_ack_nxt;
  logic [ADDR_W-1:0]             w_addr_nxt;
  logic [DATA_W-1:0]             w_do_nxt;
  logic [1:0][DATA_W-1:0]        w_rdata_nxt;

  assign w_req   = {m1_req, m0_req};
  assign w_rw    = {m1_rw, m0_rw};
  assign w_addr  = {m1_addr, m0_addr};
  assign w_wdata = {m1_wdata, m0_wdata};

  // Text-buffer writes outside vblank are held back so the display never tears.
  for (genvar g = 0; g < 2; g++) begin : g_elig
    assign w_map[g]  = (w_addr[g][ADDR_W-1 -: 4] == TB_PAGE);
    assign w_elig[g] = w_req[g] & ~(VBLANK_ONLY & w_rw[g] & w_map[g] & ~vblank);
  end

  rr_arb2 u_rr (
    .i_elig   (w_elig),
    .i_last   (r_last),
    .o_valid  (w_valid),
    .o_winner (w_win)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rw_nxt    = r_rw;
    w_map_nxt   = r_map;
    w_gid_nxt   = r_gid;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_do_nxt    = r_do;
    w_rdata_nxt = r_rdata;
    w_we_nxt    = 1'b0;
    w_oe_nxt    = 1'b0;
    w_ack_nxt   = 2'b00;
    case (r_state)
      IDLE: if (w_valid) begin
        w_state_nxt = ISSUE;
        w_gid_nxt   = w_win;
        w_rw_nxt    = w_rw[w_win];
        w_map_nxt   = w_map[w_win];
        w_addr_nxt  = w_addr[w_win];
        w_do_nxt    = w_wdata[w_win];
        w_we_nxt    = w_rw[w_win] & w_map[w_win];
        w_oe_nxt    = ~w_rw[w_win] & w_map[w_win];
      end
      ISSUE: if (r_map && !r_rw && RD_LAT > 1) begin
        w_state_nxt = WAIT;
        w_oe_nxt    = 1'b1;
        w_cnt_nxt   = WAIT_N;
      end else begin
        w_state_nxt      = ACK;
        w_ack_nxt[r_gid] = 1'b1;
        if (!r_rw) w_rdata_nxt[r_gid] = r_map ? bus_di : DATA_W'(UNMAPPED_DATA);
      end
      WAIT: if (r_cnt == 2'd0) begin
        w_state_nxt        = ACK;
        w_ack_nxt[r_gid]   = 1'b1;
        w_rdata_nxt[r_gid] = bus_di;
      end else begin
        w_oe_nxt  = 1'b1;
        w_cnt_nxt = r_cnt - 2'd1;
      end
      ACK: begin
        w_state_nxt = IDLE;
        w_last_nxt  = r_gid;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rw    <= 1'b0;
      r_map   <= 1'b0;
      r_gid   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 2'd0;
      r_addr  <= '0;
      r_do    <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_oe    <= 1'b0;
      r_ack   <= 2'b00;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rw    <= w_rw_nxt;
      r_map   <= w_map_nxt;
      r_gid   <= w_gid_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_do    <= w_do_nxt;
      r_rdata <= w_rdata_nxt;
      r_we    <= w_we_nxt;
      r_oe    <= w_oe_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign m0_ack   = r_ack[0];
  assign m1_ack   = r_ack[1];
  assign m0_rdata = r_rdata[0];
  assign m1_rdata = r_rdata[1];
  assign bus_addr = r_addr;
  assign bus_do   = r_do;
  assign tb_we    = r_we;
  assign tb_oe    = r_oe;
  assign busy     = r_busy;
  assign grant_id = r_gid;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (RD_LAT=2, VBLANK_ONLY=1) with a small text-buffer read model.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset, vblank;
  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [11:0] m0_addr, m1_addr, bus_addr;
  logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, bus_do, bus_di;
  logic        m0_ack, m1_ack, tb_we, tb_oe, busy, grant_id;
  logic        oe_d1 = 1'b0, oe_d2 = 1'b0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(12), .DATA_W(8), .TB_PAGE(4'h4), .RD_LAT(2), .VBLANK_ONLY(1'b1)) dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_do(bus_do), .bus_di(bus_di),
    .tb_we(tb_we), .tb_oe(tb_oe), .busy(busy), .grant_id(grant_id)
  );

  // Text buffer: data is valid only in the cycle just before the RD_LAT=2 sample edge.
  always @(posedge clk) begin
    oe_d1 <= tb_oe;
    oe_d2 <= oe_d1;
  end
  assign bus_di = (oe_d1 && !oe_d2) ? 8'h3C : 8'hEE;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; vblank = 1'b0;
    m0_req = 0; m0_rw = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_rw = 0; m1_addr = '0; m1_wdata = '0;
    #3;
    checks++;
    if ({tb_we, tb_oe, busy, m0_ack, m1_ack, grant_id, bus_addr, bus_do, m0_rdata, m1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs we=%b oe=%b busy=%b ack=%b%b gid=%b addr=%h do=%h rd0=%h rd1=%h want all 0",
               tb_we, tb_oe, busy, m1_ack, m0_ack, grant_id, bus_addr, bus_do, m0_rdata, m1_rdata);
    end
    step; step;
    reset = 1'b1;
    step;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b want 0", busy); end
  endtask

  task automatic test_single_write;
    vblank = 1; m0_rw = 1; m0_addr = 12'h412; m0_wdata = 8'h5A; m0_req = 1;
    step;
    checks++;
    if ({tb_we, tb_oe, busy, grant_id, m0_ack, bus_addr, bus_do} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h412, 8'h5A}) begin
      errors++;
      $display("FAIL wr_issue we=%b oe=%b busy=%b gid=%b ack=%b addr=%h do=%h want 1 0 1 0 0 412 5a",
               tb_we, tb_oe, busy, grant_id, m0_ack, bus_addr, bus_do);
    end
    step;
    checks++;
    if ({m0_ack, m1_ack, tb_we} !== 3'b100) begin
      errors++; $display("FAIL wr_ack ack0=%b ack1=%b we=%b want 1 0 0", m0_ack, m1_ack, tb_we);
    end
    m0_req = 0;
    step;
    checks++;
    if ({m0_ack, tb_we, busy} !== 3'b000) begin
      errors++; $display("FAIL wr_done ack0=%b we=%b busy=%b want 0 0 0", m0_ack, tb_we, busy);
    end
  endtask

  task automatic test_read_lat2;
    m1_rw = 0; m1_addr = 12'h400; m1_req = 1;
    step;
    checks++;
    if ({tb_oe, tb_we, grant_id} !== 3'b101) begin
      errors++; $display("FAIL rd_issue oe=%b we=%b gid=%b want 1 0 1", tb_oe, tb_we, grant_id);
    end
    step;
    checks++;
    if ({tb_oe, m1_ack} !== 2'b10) begin
      errors++; $display("FAIL rd_wait oe=%b ack1=%b want 1 0", tb_oe, m1_ack);
    end
    step;
    checks++;
    if ({m1_ack, m0_ack, tb_oe, m1_rdata, m0_rdata} !== {3'b100, 8'h3C, 8'h00}) begin
      errors++; $display("FAIL rd_ack ack1=%b ack0=%b oe=%b rd1=%h rd0=%h want 1 0 0 3c 00",
                         m1_ack, m0_ack, tb_oe, m1_rdata, m0_rdata);
    end
    m1_req = 0;
    step;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rd_done busy=%b want 0", busy); end
  endtask

  task automatic test_contention;
    int  nacks = 0, last_cyc = -1, cyc = 0, clash = 0;
    bit  exp_id = 1'b0;
    vblank = 1;
    m0_rw = 1; m0_addr = 12'h4A0; m0_wdata = 8'h11;
    m1_rw = 1; m1_addr = 12'h4B0; m1_wdata = 8'h22;
    m0_req = 1; m1_req = 1;
    while (nacks < 20 && cyc < 100) begin
      step; cyc++;
      if (tb_we && tb_oe) clash++;
      if (tb_we) begin
        checks++;
        if (bus_do !== (grant_id ? 8'h22 : 8'h11)) begin
          errors++; $display("FAIL rr_data gid=%b do=%h want %h", grant_id, bus_do, grant_id ? 8'h22 : 8'h11);
        end
      end
      if (m0_ack || m1_ack) begin
        checks++;
        if ({m1_ack, m0_ack} !== (exp_id ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_order n=%0d ack=%b%b want m%0d", nacks, m1_ack, m0_ack, exp_id);
        end
        checks++;
        if (cyc - last_cyc !== ((last_cyc < 0) ? cyc - last_cyc : 3) || (last_cyc < 0 && cyc != 2)) begin
          errors++; $display("FAIL rr_spacing n=%0d cyc=%0d prev=%0d want gap 3 (first at 2)", nacks, cyc, last_cyc);
        end
        last_cyc = cyc; exp_id = ~exp_id; nacks++;
      end
    end
    m0_req = 0; m1_req = 0;
    checks++;
    if (nacks != 20) begin errors++; $display("FAIL rr_count acks=%0d want 20", nacks); end
    checks++;
    if (clash != 0) begin errors++; $display("FAIL rr_strobe_clash cycles=%0d want 0", clash); end
    step;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle busy=%b want 0", busy); end
  endtask

  task automatic test_vblank_gating;
    int we_cnt = 0, m0a = 0, m1_done = 0;
    bit found = 0;
    vblank = 0;
    m0_rw = 1; m0_addr = 12'h401; m0_wdata = 8'h77; m0_req = 1;
    m1_rw = 0; m1_addr = 12'h402; m1_req = 1;
    for (int i = 0; i < 10; i++) begin
      step;
      if (tb_we) we_cnt++;
      if (m0_ack) m0a++;
      if (m1_ack) begin
        m1_done++;
        checks++;
        if (m1_rdata !== 8'h3C) begin errors++; $display("FAIL gate_m1_rdata rd1=%h want 3c", m1_rdata); end
        m1_req = 0;
      end
    end
    checks++;
    if ({we_cnt, m0a, m1_done} !== {32'd0, 32'd0, 32'd1}) begin
      errors++; $display("FAIL gate_hold we_cycles=%0d m0_acks=%0d m1_acks=%0d want 0 0 1", we_cnt, m0a, m1_done);
    end
    vblank = 1;
    for (int i = 0; i < 2; i++) begin
      step;
      if (tb_we && !found) begin
        found = 1;
        checks++;
        if ({bus_addr, bus_do, grant_id} !== {12'h401, 8'h77, 1'b0}) begin
          errors++; $display("FAIL gate_issue addr=%h do=%h gid=%b want 401 77 0", bus_addr, bus_do, grant_id);
        end
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL gate_release we_seen=0 want 1 within 2 cycles"); end
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      step;
      if (m0_ack) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL gate_ack m0_ack not seen within 4 cycles"); end
    m0_req = 0;
    step;
  endtask

  task automatic test_unmapped;
    m0_rw = 0; m0_addr = 12'h800; m0_req = 1;
    step;
    checks++;
    if ({tb_we, tb_oe, busy} !== 3'b001) begin
      errors++; $display("FAIL unm_issue we=%b oe=%b busy=%b want 0 0 1", tb_we, tb_oe, busy);
    end
    step;
    checks++;
    if ({m0_ack, m0_rdata, m1_rdata} !== {1'b1, 8'hFF, 8'h3C}) begin
      errors++; $display("FAIL unm_ack ack0=%b rd0=%h rd1=%h want 1 ff 3c", m0_ack, m0_rdata, m1_rdata);
    end
    m0_req = 0;
    step;
  endtask

  task automatic test_reset_mid_read;
    int acks_in_reset = 0;
    bit got = 0;
    m0_rw = 0; m0_addr = 12'h410; m0_req = 1;
    step; step;
    checks++;
    if (tb_oe !== 1'b1) begin errors++; $display("FAIL rst_pre_wait oe=%b want 1", tb_oe); end
    m1_rw = 0; m1_addr = 12'h420; m1_req = 1;
    #2 reset = 0;
    #1;
    checks++;
    if ({tb_oe, busy, m0_rdata} !== {2'b00, 8'h00}) begin
      errors++; $display("FAIL rst_async oe=%b busy=%b rd0=%h want 0 0 00", tb_oe, busy, m0_rdata);
    end
    for (int i = 0; i < 2; i++) begin
      step;
      if (m0_ack || m1_ack) acks_in_reset++;
    end
    checks++;
    if (acks_in_reset != 0) begin errors++; $display("FAIL rst_no_ack acks=%0d want 0", acks_in_reset); end
    reset = 1;
    step;
    checks++;
    if ({grant_id, tb_oe, bus_addr} !== {2'b01, 12'h410}) begin
      errors++; $display("FAIL rst_regrant gid=%b oe=%b addr=%h want 0 1 410", grant_id, tb_oe, bus_addr);
    end
    step; step;
    checks++;
    if ({m0_ack, m1_ack, m0_rdata} !== {2'b10, 8'h3C}) begin
      errors++; $display("FAIL rst_complete ack0=%b ack1=%b rd0=%h want 1 0 3c", m0_ack, m1_ack, m0_rdata);
    end
    m0_req = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step;
      if (m1_ack) got = 1;
    end
    checks++;
    if (!got || m1_rdata !== 8'h3C) begin
      errors++; $display("FAIL rst_m1_follow acked=%b rd1=%h want 1 3c", got, m1_rdata);
    end
    m1_req = 0;
    step;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single_write;
    test_read_lat2;
    test_contention;
    test_vblank_gating;
    test_unmapped;
    test_reset_mid_read;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single memory-mapped peripheral bus (12-bit address, 8-bit data) between two bus masters.
- Typical masters: the CPU-side test driver and a vsync-triggered update engine.
- Decodes the text-buffer page, sequences each access as a registered transaction, and drives the text buffer's we/oe strobes.
- Optionally holds text-buffer writes until vertical blank so the display never tears mid-frame.

Parameters:
- ADDR_W, 12, bus address width.
- DATA_W, 8, bus data width.
- TB_PAGE, 4'h4, addr[11:8] value that selects the text buffer.
- RD_LAT, 1, cycles from the oe strobe until bus_di is valid (1..3).
- VBLANK_ONLY, 1, when 1, text-buffer writes are granted only while vblank=1.

Ports:
- clk  in  1  system clock (PLL output).
- reset  in  1  asynchronous, active-low reset.
- vblank  in  1  high during vertical blank; synchronous to clk.
- m0_req  in  1  master 0 request; held high until m0_ack.
- m0_rw  in  1  1=write, 0=read; stable while m0_req is high.
- m0_addr  in  ADDR_W  master 0 address; stable while m0_req is high.
- m0_wdata  in  DATA_W  master 0 write data; stable while m0_req is high.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_W  read data; valid in the m0_ack cycle.
- m1_req, m1_rw, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0 for master 1.
- bus_addr  out  ADDR_W  shared address to peripherals.
- bus_do  out  DATA_W  write data to peripherals.
- bus_di  in  DATA_W  read data from the text buffer.
- tb_we  out  1  text-buffer write strobe.
- tb_oe  out  1  text-buffer output-enable strobe.
- busy  out  1  high in every state other than IDLE.
- grant_id  out  1  master owning the current transaction.

Behaviour:
- Reset (async, reset=0) forces the following, regardless of any in-flight transaction:
  - state=IDLE.
  - tb_we, tb_oe, m0_ack, m1_ack, busy all 0.
  - bus_addr, bus_do, m0_rdata, m1_rdata all 0.
  - grant_id=0; last_grant=1, so m0 wins the first contention.
- A reset mid-transaction produces no ack. The aborted master re-presents its request after reset.
- All outputs are registered.
- Eligibility: mN is eligible when mN_req=1 AND NOT (VBLANK_ONLY AND mN_rw=1 AND addr[11:8]==TB_PAGE AND vblank=0).
  - Reads and unmapped accesses are always eligible.
- State machine, one transition per clk:
  - IDLE: if no master is eligible, stay. If one is eligible, grant it. If both are eligible, grant the one that is not last_grant (round-robin). Latch addr, rw and wdata, set grant_id, go to ISSUE.
  - ISSUE (1 cycle): drive bus_addr and bus_do. For a mapped write, tb_we=1. For a mapped read, tb_oe=1. For an unmapped access, no strobe. Go to WAIT if this is a mapped read and RD_LAT>1; otherwise go to ACK.
  - WAIT: hold tb_oe=1 and count RD_LAT-1 cycles, then go to ACK.
  - ACK (1 cycle): drop all strobes. Pulse ack for the granted master. For a mapped read, rdata <= bus_di sampled at ISSUE+RD_LAT; for an unmapped read, rdata <= 8'hFF. Set last_grant=grant_id, go to IDLE.
- Latency from the request being sampled in IDLE at cycle T:
  - Writes and unmapped accesses: strobe at T+1, ack at T+2.
  - Reads: ack at T+1+RD_LAT.
- Throughput: one transaction per 3 cycles minimum. IDLE is always visited between transactions.
- Strobes are mutually exclusive: never tb_we and tb_oe together. Each is asserted only while busy=1.
- The rdata of the non-granted master holds its previous value.
- A master may re-raise req in the cycle after its ack. Round-robin still applies, so the other master wins if it is waiting.
- vblank falling while a write is already in ISSUE does not abort it. Gating applies only at the grant decision.
- A request dropped before ack is a protocol violation. Behaviour is undefined; the bench flags it as an error.

Decomposition:
- Shared package bus_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, ACK);
  - the TB_PAGE constant;
  - the UNMAPPED_DATA=8'hFF constant;
  - the ADDR_W and DATA_W defaults.
- One sub-module, rr_arb2: a two-way round-robin picker. Inputs: eligibility vector and last_grant. Outputs: valid and winner. Purely combinational, instantiated in the IDLE decision.

Test Plan:
- Single write: m0 writes addr=0x412, data=0x5A with vblank=1 -> tb_we=1 for exactly 1 cycle at T+1 with bus_addr=0x412 and bus_do=0x5A; m0_ack at T+2.
- Read, RD_LAT=2: bus_di model returns 0x3C two cycles after tb_oe, m1 reads 0x400 -> tb_oe high for 2 cycles, m1_ack at T+3, m1_rdata=0x3C.
- Contention: m0 and m1 hold continuous writes -> grants alternate m0, m1, m0, m1; each ack is 3 cycles apart; no starvation over 20 transactions.
- Vblank gating: m0 writes 0x401 with vblank=0 for 10 cycles while m1 reads 0x402 -> m1 is served and m0 sees no tb_we. After vblank rises, the m0 write issues within 2 cycles.
- Unmapped access: m0 reads 0x800 -> no tb_we or tb_oe; m0_ack at T+2; m0_rdata=0xFF.
- Reset mid-read: assert reset=0 during WAIT -> tb_oe drops asynchronously and no ack occurs. After release, the same request completes normally with m0 priority.
